// File: rtl/xgriscv_mem_arbiter_pkg.sv
// Shared constants for the unified-memory arbiter.
// Contents:
//   ARB_IDLE/ARB_ISSUE/ARB_WAIT/ARB_DONE  2-bit FSM state encodings
//   ARB_OWN_FETCH/ARB_OWN_DATA            owner codes (which port holds the memory)
//   ARB_CNT_W                             width of the starvation counter (STARVE_MAX <= 7)
package xgriscv_mem_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_ISSUE = 2'd1;
  localparam logic [1:0] ARB_WAIT  = 2'd2;
  localparam logic [1:0] ARB_DONE  = 2'd3;

  localparam logic ARB_OWN_FETCH = 1'b0;
  localparam logic ARB_OWN_DATA  = 1'b1;

  localparam int ARB_CNT_W = 3;

endpackage

// File: rtl/xgriscv_arb_prio.sv
// Winner selection and starvation counter for the memory arbiter.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   f_req,d_req  pending fetch / data requests
//   grant        arbitration happens this cycle (top is in IDLE with a request)
//   winner       ARB_OWN_DATA or ARB_OWN_FETCH, combinational
//   starve_cnt   consecutive data grants taken while fetch was waiting
module xgriscv_arb_prio
  import xgriscv_mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 f_req,
  input  logic                 d_req,
  input  logic                 grant,
  output logic                 winner,
  output logic [ARB_CNT_W-1:0] starve_cnt
);

  localparam logic [ARB_CNT_W-1:0] CNT_MAX = ARB_CNT_W'(STARVE_MAX);

  // Data wins by default; once fetch has been passed over CNT_MAX times in a
  // row, fetch takes the next grant.
  always_comb begin
    winner = ARB_OWN_FETCH;
    if (d_req && !(f_req && (starve_cnt == CNT_MAX)))
      winner = ARB_OWN_DATA;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (grant) begin
      if ((winner == ARB_OWN_DATA) && f_req) begin
        if (starve_cnt != CNT_MAX)
          starve_cnt <= starve_cnt + 1'b1;
      end else begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/xgriscv_mem_arbiter.sv
// Shares one single-ported memory between the fetch and data ports, one
// transaction at a time.
// Handshakes:
//   requester side: f_req/d_req rise with payload and stay up (payload stable)
//   until the matching one-cycle f_valid/d_valid; memory side: m_req and its
//   payload stay stable until a cycle with m_ready=1; the completion
//   (m_rvalid) may arrive in that same cycle or any later one.
// Ports:
//   f_*      fetch port (read only)
//   d_*      data port (loads and stores)
//   m_*      memory port
//   stall    a requester is waiting for its completion (combinational)
//   dbg_state, dbg_starve_cnt   FSM state and starvation counter
module xgriscv_mem_arbiter
  import xgriscv_mem_arbiter_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ADDR_SIZE  = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 f_req,
  input  logic [ADDR_SIZE-1:0] f_addr,
  output logic [XLEN-1:0]      f_rdata,
  output logic                 f_valid,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [3:0]           d_amp,
  input  logic [ADDR_SIZE-1:0] d_addr,
  input  logic [XLEN-1:0]      d_wdata,
  output logic [XLEN-1:0]      d_rdata,
  output logic                 d_valid,
  output logic                 m_req,
  output logic                 m_we,
  output logic [3:0]           m_amp,
  output logic [ADDR_SIZE-1:0] m_addr,
  output logic [XLEN-1:0]      m_wdata,
  input  logic                 m_ready,
  input  logic                 m_rvalid,
  input  logic [XLEN-1:0]      m_rdata,
  output logic                 stall,
  output logic [1:0]           dbg_state,
  output logic [ARB_CNT_W-1:0] dbg_starve_cnt
);

  logic [1:0] state;
  logic       owner;
  logic       winner;
  logic       grant;
  logic       complete;

  assign grant = (state == ARB_IDLE) && (f_req || d_req);

  // m_rvalid only counts once the request has been accepted; in ISSUE that
  // means together with m_ready, otherwise it is a stray pulse and dropped.
  assign complete = ((state == ARB_ISSUE) && m_ready && m_rvalid) ||
                    ((state == ARB_WAIT) && m_rvalid);

  assign stall          = (f_req && !f_valid) || (d_req && !d_valid);
  assign dbg_state      = state;

  xgriscv_arb_prio #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .clk        (clk),
    .reset      (reset),
    .f_req      (f_req),
    .d_req      (d_req),
    .grant      (grant),
    .winner     (winner),
    .starve_cnt (dbg_starve_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ARB_IDLE;
      owner   <= ARB_OWN_FETCH;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_amp   <= 4'b0000;
      m_addr  <= '0;
      m_wdata <= '0;
      f_valid <= 1'b0;
      d_valid <= 1'b0;
      f_rdata <= '0;
      d_rdata <= '0;
    end else begin
      f_valid <= 1'b0;
      d_valid <= 1'b0;

      case (state)
        ARB_IDLE: begin
          if (grant) begin
            owner <= winner;
            m_req <= 1'b1;
            state <= ARB_ISSUE;
            if (winner == ARB_OWN_DATA) begin
              m_we    <= d_we;
              m_amp   <= d_amp;
              m_addr  <= d_addr;
              m_wdata <= d_wdata;
            end else begin
              m_we    <= 1'b0;
              m_amp   <= 4'b1111;
              m_addr  <= f_addr;
              m_wdata <= '0;
            end
          end
        end
        ARB_ISSUE: begin
          if (m_ready) begin
            m_req <= 1'b0;
            state <= m_rvalid ? ARB_DONE : ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          if (m_rvalid)
            state <= ARB_DONE;
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase

      // The valid pulse is registered so it is high exactly while in DONE.
      if (complete) begin
        if (owner == ARB_OWN_FETCH) begin
          f_valid <= 1'b1;
          f_rdata <= m_rdata;
        end else begin
          d_valid <= 1'b1;
          if (!m_we)
            d_rdata <= m_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_xgriscv_mem_arbiter.sv
module tb_xgriscv_mem_arbiter;
  import xgriscv_mem_arbiter_pkg::*;

  localparam int XLEN = 32;
  localparam int AW   = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            f_req;
  logic [AW-1:0]   f_addr;
  logic [XLEN-1:0] f_rdata;
  logic            f_valid;
  logic            d_req;
  logic            d_we;
  logic [3:0]      d_amp;
  logic [AW-1:0]   d_addr;
  logic [XLEN-1:0] d_wdata;
  logic [XLEN-1:0] d_rdata;
  logic            d_valid;
  logic            m_req;
  logic            m_we;
  logic [3:0]      m_amp;
  logic [AW-1:0]   m_addr;
  logic [XLEN-1:0] m_wdata;
  logic            m_ready;
  logic            m_rvalid;
  logic [XLEN-1:0] m_rdata;
  logic            stall;
  logic [1:0]      dbg_state;
  logic [2:0]      dbg_starve_cnt;

  int tests = 0;
  int fails = 0;

  // {is_data, rdata} expected at each valid pulse
  logic [XLEN:0]   exp_q[$];
  logic [XLEN-1:0] model_f = '0;
  logic [XLEN-1:0] model_d = '0;

  xgriscv_mem_arbiter #(
    .XLEN(XLEN), .ADDR_SIZE(AW), .STARVE_MAX(4)
  ) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_rdata(f_rdata), .f_valid(f_valid),
    .d_req(d_req), .d_we(d_we), .d_amp(d_amp), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_valid(d_valid),
    .m_req(m_req), .m_we(m_we), .m_amp(m_amp), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_ready(m_ready), .m_rvalid(m_rvalid),
    .m_rdata(m_rdata), .stall(stall),
    .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic push_fetch(input logic [XLEN-1:0] rd);
    model_f = rd;
    exp_q.push_back({1'b0, rd});
  endtask

  task automatic push_load(input logic [XLEN-1:0] rd);
    model_d = rd;
    exp_q.push_back({1'b1, rd});
  endtask

  task automatic push_store();
    exp_q.push_back({1'b1, model_d});
  endtask

  always @(negedge clk) begin
    if (!reset && (f_valid === 1'b1 || d_valid === 1'b1)) begin
      check("single_valid", 64'(f_valid & d_valid), 64'd0);
      if (exp_q.size() == 0) begin
        check("spurious_valid", 64'({f_valid, d_valid}), 64'd0);
      end else begin
        logic [XLEN:0] e;
        e = exp_q.pop_front();
        check("valid_owner", 64'(d_valid), 64'(e[XLEN]));
        if (d_valid === 1'b1) check("d_rdata", 64'(d_rdata), 64'(e[XLEN-1:0]));
        else                  check("f_rdata", 64'(f_rdata), 64'(e[XLEN-1:0]));
      end
    end
  end

  // ---------------- memory driver ----------------
  // Waits for the grant, checks the payload, applies bp cycles of
  // backpressure, then accepts and completes (same cycle if same=1).
  // Returns in the DONE cycle.
  task automatic do_mem(input logic exp_we, input logic [3:0] exp_amp,
                        input logic [AW-1:0] exp_addr, input logic [XLEN-1:0] exp_wdata,
                        input int bp, input bit same, input logic [XLEN-1:0] rd);
    int n;
    n = 0;
    while (m_req !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    check("grant_timeout", 64'(m_req), 64'd1);
    if (m_req !== 1'b1) return;
    check("grant_we",   64'(m_we),   64'(exp_we));
    check("grant_amp",  64'(m_amp),  64'(exp_amp));
    check("grant_addr", 64'(m_addr), 64'(exp_addr));
    if (exp_we) check("grant_wdata", 64'(m_wdata), 64'(exp_wdata));
    check("stall_issue", 64'(stall), 64'd1);
    for (int i = 0; i < bp; i++) begin
      m_ready  = 1'b0;
      // stray completion without acceptance must be ignored
      m_rvalid = (i == 1);
      m_rdata  = 32'hBAD0_BAD0;
      cyc();
      m_rvalid = 1'b0;
      check("bp_m_req",  64'(m_req),  64'd1);
      check("bp_addr",   64'(m_addr), 64'(exp_addr));
      check("bp_we",     64'(m_we),   64'(exp_we));
      check("bp_amp",    64'(m_amp),  64'(exp_amp));
      check("bp_stall",  64'(stall),  64'd1);
    end
    m_ready  = 1'b1;
    m_rvalid = same;
    m_rdata  = rd;
    cyc();
    m_ready  = 1'b0;
    m_rvalid = 1'b0;
    if (!same) begin
      check("wait_state", 64'(dbg_state), 64'(ARB_WAIT));
      check("wait_m_req", 64'(m_req), 64'd0);
      m_rvalid = 1'b1;
      m_rdata  = rd;
      cyc();
      m_rvalid = 1'b0;
    end
    check("done_state", 64'(dbg_state), 64'(ARB_DONE));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"},   64'(dbg_state),      64'(ARB_IDLE));
    check({tag, "_starve"},  64'(dbg_starve_cnt), 64'd0);
    check({tag, "_m_req"},   64'(m_req),   64'd0);
    check({tag, "_m_we"},    64'(m_we),    64'd0);
    check({tag, "_m_amp"},   64'(m_amp),   64'd0);
    check({tag, "_m_addr"},  64'(m_addr),  64'd0);
    check({tag, "_m_wdata"}, 64'(m_wdata), 64'd0);
    check({tag, "_f_valid"}, 64'(f_valid), 64'd0);
    check({tag, "_d_valid"}, 64'(d_valid), 64'd0);
    check({tag, "_f_rdata"}, 64'(f_rdata), 64'd0);
    check({tag, "_d_rdata"}, 64'(d_rdata), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1;
    f_req = 1'b0; f_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_amp = 4'b0000; d_addr = '0; d_wdata = '0;
    m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    cyc();
    cyc();
    check_reset_vals("reset");
    reset = 1'b0;
    cyc();
    check("idle_stall", 64'(stall), 64'd0);

    // Fetch only, completion one cycle after acceptance.
    f_req = 1'b1; f_addr = 32'h100;
    push_fetch(32'h0050_0093);
    do_mem(1'b0, 4'b1111, 32'h100, '0, 0, 1'b0, 32'h0050_0093);
    check("fetch_done_stall", 64'(stall), 64'd0);
    f_req = 1'b0;
    cyc();

    // Simultaneous: data store first, then fetch.
    f_req = 1'b1; f_addr = 32'h104;
    d_req = 1'b1; d_we = 1'b1; d_amp = 4'b0011; d_addr = 32'h2000; d_wdata = 32'hABCD;
    push_store();
    do_mem(1'b1, 4'b0011, 32'h2000, 32'hABCD, 0, 1'b0, 32'hFFFF_FFFF);
    d_req = 1'b0; d_we = 1'b0;
    push_fetch(32'h1111_2222);
    do_mem(1'b0, 4'b1111, 32'h104, '0, 0, 1'b0, 32'h1111_2222);
    check("store_keeps_d_rdata", 64'(d_rdata), 64'(model_d));
    f_req = 1'b0;
    cyc();

    // Starvation: fetch held, data request kept up across completions.
    f_req = 1'b1; f_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b0; d_amp = 4'b1111; d_addr = 32'h2004;
    for (int i = 0; i < 4; i++) begin
      logic [XLEN-1:0] v;
      v = 32'h1000 + $urandom_range(0, 255);
      push_load(v);
      do_mem(1'b0, 4'b1111, 32'h2004, '0, 0, 1'b0, v);
      check("starve_count", 64'(dbg_starve_cnt), 64'(i + 1));
    end
    push_fetch(32'h0000_0013);
    do_mem(1'b0, 4'b1111, 32'h200, '0, 0, 1'b0, 32'h0000_0013);
    check("starve_cleared", 64'(dbg_starve_cnt), 64'd0);
    f_req = 1'b0; d_req = 1'b0;
    cyc();

    // Memory backpressure on a store.
    d_req = 1'b1; d_we = 1'b1; d_amp = 4'b1100; d_addr = 32'h2008; d_wdata = 32'h1234_5678;
    push_store();
    do_mem(1'b1, 4'b1100, 32'h2008, 32'h1234_5678, 5, 1'b0, 32'h0);
    d_req = 1'b0; d_we = 1'b0;
    cyc();

    // Same-cycle accept and complete on a load; WAIT is skipped.
    d_req = 1'b1; d_amp = 4'b1111; d_addr = 32'h200C;
    push_load(32'h55);
    do_mem(1'b0, 4'b1111, 32'h200C, '0, 0, 1'b1, 32'h55);
    d_req = 1'b0;
    cyc();

    // Reset while in WAIT, then a late completion.
    d_req = 1'b1; d_addr = 32'h3000;
    begin
      int n;
      n = 0;
      while (m_req !== 1'b1 && n < 20) begin
        cyc();
        n++;
      end
    end
    check("rst_grant", 64'(m_req), 64'd1);
    m_ready = 1'b1;
    cyc();
    m_ready = 1'b0;
    check("rst_in_wait", 64'(dbg_state), 64'(ARB_WAIT));
    reset = 1'b1; d_req = 1'b0;
    cyc();
    reset = 1'b0;
    model_f = '0; model_d = '0;
    check_reset_vals("midreset");
    cyc();
    m_rvalid = 1'b1; m_rdata = 32'hDEAD_BEEF;
    cyc();
    m_rvalid = 1'b0;
    check("late_rvalid_state", 64'(dbg_state), 64'(ARB_IDLE));
    check("late_rvalid_m_req", 64'(m_req), 64'd0);
    cyc();
    cyc();
    f_req = 1'b1; f_addr = 32'h300;
    push_fetch(32'h0000_1234);
    do_mem(1'b0, 4'b1111, 32'h300, '0, 0, 1'b0, 32'h0000_1234);
    f_req = 1'b0;
    check("post_reset_d_rdata", 64'(d_rdata), 64'd0);
    cyc();
    cyc();
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
